// File: rtl/onchip_mem_copy_engine.sv
// rtl/onchip_mem_copy_engine.sv - on-chip memory copy/fill engine (fill path under `MEMCOPY_FILL_EN)
module onchip_mem_copy_engine #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [15:0]           length,
  input  logic                  fill_mode,
  input  logic [DATA_W-1:0]     fill_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           words_done,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [15:0]       len_q, words_q;
  logic [DATA_W-1:0] hold_q;
  logic              accept, last_word, fill_act;
  logic              cs_int, wr_int;

`ifdef MEMCOPY_FILL_EN
  logic              fill_q;
  logic [DATA_W-1:0] fill_data_q;
  assign fill_act = fill_q;
`else
  logic unused_fill;
  assign unused_fill = ^{fill_mode, fill_data};
  assign fill_act    = 1'b0;
`endif

  assign accept    = (state == IDLE) && start;
  assign last_word = (words_q == len_q - 16'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (length == 16'd0)
            state_nxt = DONE;
`ifdef MEMCOPY_FILL_EN
          else if (fill_mode)
            state_nxt = WRITE;
`endif
          else
            state_nxt = READ;
        end
      end
      READ:    state_nxt = LATCH;
      LATCH:   state_nxt = WRITE;
      WRITE:   state_nxt = last_word ? DONE : (fill_act ? WRITE : READ);
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    cs_int        = 1'b0;
    wr_int        = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      READ: begin
        busy        = 1'b1;
        cs_int      = 1'b1;
        mem_address = src_q;
      end
      LATCH: begin
        busy        = 1'b1;
        mem_address = src_q;
      end
      WRITE: begin
        busy        = 1'b1;
        cs_int      = 1'b1;
        wr_int      = 1'b1;
        mem_address = dst_q;
`ifdef MEMCOPY_FILL_EN
        mem_writedata = fill_q ? fill_data_q : hold_q;
`else
        mem_writedata = hold_q;
`endif
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Gating with reset_n keeps an aborted command from landing a write on the reset edge.
  assign mem_chipselect = cs_int & reset_n;
  assign mem_write      = wr_int & reset_n;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;
  assign words_done     = words_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      words_q <= '0;
      hold_q  <= '0;
`ifdef MEMCOPY_FILL_EN
      fill_q      <= 1'b0;
      fill_data_q <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        src_q   <= src_addr;
        dst_q   <= dst_addr;
        len_q   <= length;
        words_q <= '0;
`ifdef MEMCOPY_FILL_EN
        fill_q      <= fill_mode;
        fill_data_q <= fill_data;
`endif
      end
      if (state == LATCH)
        hold_q <= mem_readdata;
      if (state == WRITE) begin
        src_q   <= src_q + 1'b1;
        dst_q   <= dst_q + 1'b1;
        words_q <= words_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_onchip_mem_copy_engine.sv
// tb/tb_onchip_mem_copy_engine.sv - directed table-driven bench for onchip_mem_copy_engine
module tb_onchip_mem_copy_engine;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
`ifdef MEMCOPY_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [15:0]       length = '0;
  logic              fill_mode = 1'b0;
  logic [DATA_W-1:0] fill_data = '0;
  logic              busy, done;
  logic [15:0]       words_done;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata = '0;

  onchip_mem_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .length(length), .fill_mode(fill_mode),
    .fill_data(fill_data), .busy(busy), .done(done), .words_done(words_done),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input logic [ADDR_W-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Single-port memory model: registered address, read data one cycle after the read.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              mem_init = 1'b0;
  logic [ADDR_W-1:0] rd_log [$];
  int                done_total = 0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < (1 << ADDR_W); a++) mem[a] <= pattern(ADDR_W'(a));
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write) mem[mem_address] <= mem_writedata;
      else begin
        mem_readdata <= mem[mem_address];
        rd_log.push_back(mem_address);
      end
    end
  end

  always @(negedge clk) if (done) done_total++;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                         input logic [15:0] len, input logic fm, input logic [31:0] fd,
                         input int inj_cycle,
                         output int busy_n, output int done_n, output int done_at,
                         output int cs_n);
    busy_n = 0; done_n = 0; done_at = 0; cs_n = 0;
    @(posedge clk); #1;
    start = 1'b1; src_addr = s; dst_addr = d; length = len; fill_mode = fm; fill_data = fd;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (mem_chipselect) cs_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = c;
      end
      if (c == inj_cycle) begin
        start = 1'b1; src_addr = 15'h0050; dst_addr = 15'h0700; length = 16'd2; fill_mode = 1'b0;
      end else start = 1'b0;
      if (done_at != 0 && c >= done_at + 3) break;
    end
    if (done_at == 0) check("cmd_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [15:0]       len;
    logic              fill;
    int                exp_busy;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int bn, dn, da, cn, base, dt0;
    logic [31:0] exp_w;

    vecs[0] = '{src: 15'h0100, dst: 15'h0200, len: 16'd4, fill: 1'b0, exp_busy: 12};
    vecs[1] = '{src: 15'h0010, dst: 15'h0020, len: 16'd0, fill: 1'b0, exp_busy: 0};
    vecs[2] = '{src: 15'h7FFE, dst: 15'h0010, len: 16'd3, fill: 1'b0, exp_busy: 9};
    vecs[3] = '{src: 15'h1000, dst: 15'h2000, len: 16'd1, fill: 1'b0, exp_busy: 3};
    vecs[4] = '{src: 15'h0400, dst: 15'h0300, len: 16'd8, fill: 1'b1, exp_busy: FILL_EN ? 8 : 24};

    @(posedge clk); #1 mem_init = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_words_done", words_done, 0);
    check("rst_cs", mem_chipselect, 0);
    check("rst_write", mem_write, 0);
    check("rst_addr", mem_address, 0);
    check("rst_wdata", mem_writedata, 0);
    check("rst_be", mem_byteenable, 4'hF);
    check("rst_clken", mem_clken, 1);
    @(posedge clk); #1 reset_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      base = rd_log.size();
      run_cmd(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fill, 32'hDEADBEEF, 0, bn, dn, da, cn);
      check($sformatf("v%0d_busy_cycles", v), bn, vecs[v].exp_busy);
      check($sformatf("v%0d_done_pulses", v), dn, 1);
      check($sformatf("v%0d_done_at", v), da, vecs[v].exp_busy + 1);
      check($sformatf("v%0d_cs_cycles", v), cn,
            (vecs[v].fill && FILL_EN) ? vecs[v].len : 2 * vecs[v].len);
      check($sformatf("v%0d_words_done", v), words_done, vecs[v].len);
      for (int i = 0; i < vecs[v].len; i++) begin
        exp_w = (vecs[v].fill && FILL_EN) ? 32'hDEADBEEF : pattern(vecs[v].src + ADDR_W'(i));
        check($sformatf("v%0d_mem[%0h]", v, vecs[v].dst + ADDR_W'(i)),
              mem[vecs[v].dst + ADDR_W'(i)], exp_w);
      end
      if (v == 1) check("len0_dst_untouched", mem[15'h0020], pattern(15'h0020));
      if (v == 2) begin
        check("wrap_reads", rd_log.size() - base, 3);
        if (rd_log.size() - base == 3) begin
          check("wrap_rd0", rd_log[base], 15'h7FFE);
          check("wrap_rd1", rd_log[base+1], 15'h7FFF);
          check("wrap_rd2", rd_log[base+2], 15'h0000);
        end
      end
    end

    // Overlapping ascending copy replicates the first source word.
    run_cmd(15'h0800, 15'h0801, 16'd3, 1'b0, 32'h0, 0, bn, dn, da, cn);
    for (int i = 1; i <= 3; i++)
      check($sformatf("overlap_mem[%0h]", 15'h0800 + i), mem[15'h0800 + ADDR_W'(i)], pattern(15'h0800));

    // Start pulsed mid-command must be ignored.
    run_cmd(15'h0900, 15'h0A00, 16'd4, 1'b0, 32'h0, 4, bn, dn, da, cn);
    check("inj_busy_cycles", bn, 12);
    check("inj_done_pulses", dn, 1);
    check("inj_words_done", words_done, 4);
    check("inj_mem_a03", mem[15'h0A03], pattern(15'h0903));
    check("inj_mem_700", mem[15'h0700], pattern(15'h0700));

    // Reset during the second WRITE of a 4-word copy.
    dt0 = done_total;
    @(posedge clk); #1;
    start = 1'b1; src_addr = 15'h0500; dst_addr = 15'h0600; length = 16'd4; fill_mode = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_in_write", mem_write, 1);
    reset_n = 1'b0; start = 1'b1;
    @(negedge clk);
    check("abort_cs_gated", mem_chipselect, 0);
    check("abort_wr_gated", mem_write, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_words_done", words_done, 0);
    check("abort_addr", mem_address, 0);
    check("abort_wdata", mem_writedata, 0);
    @(posedge clk); #1 reset_n = 1'b1; start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("abort_idle_after", busy, 0);
    check("abort_no_done", done_total - dt0, 0);
    check("abort_mem_600", mem[15'h0600], pattern(15'h0500));
    check("abort_mem_601", mem[15'h0601], pattern(15'h0601));
    check("abort_mem_602", mem[15'h0602], pattern(15'h0602));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
